id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register sitting directly downstream of the control-select mux in the hazard-detection datapath. Captures the (possibly bubbled) control bundle plus ID-stage operands every cycle and presents them to the EX stage. Supports stall (hold), flush (kill) and bubble tracking via a valid bit, so EX/MEM logic can tell real instructions from inserted NOPs.

Parameters:
DATA_W, 32, width of PC+4, register operands and sign-extended immediate
REG_AW, 5, register-address width (rs/rt/rd)
CNT_W, 16, width of bubble counter (optional feature only)

Ports:
clk_i  in  1  pipeline clock, all state updates on rising edge
rst_i  in  1  asynchronous reset, active-low
stall_i  in  1  1 = hold all stored contents this cycle
flush_i  in  1  1 = load a bubble (branch taken / exception kill)
ctrl_sel_i  in  1  control-select from hazard unit; 0 = upstream inserted a bubble
regwrite_i, memtoreg_i, branch_i, memread_i, memwrite_i, alusrc_i, regdst_i  in  1 each  control bundle from mux
aluop_i  in  2  ALU op class from mux
pc4_i  in  DATA_W  PC+4 of ID instruction
rs_data_i, rt_data_i  in  DATA_W  register-file read data
imm_i  in  DATA_W  sign-extended immediate
rs_i, rt_i, rd_i  in  REG_AW  register addresses
regwrite_o, memtoreg_o, branch_o, memread_o, memwrite_o, alusrc_o, regdst_o  out  1 each  registered control
aluop_o  out  2  registered ALU op
pc4_o, rs_data_o, rt_data_o, imm_o  out  DATA_W  registered data
rs_o, rt_o, rd_o  out  REG_AW  registered addresses
valid_o  out  1  1 = EX holds a real instruction

Behaviour:
- All outputs registered; latency 1 cycle from inputs to outputs.
- Reset (rst_i=0, async, immediate): every output 0, including valid_o=0; held while rst_i low. Reset mid-stall/flush wins over everything.
- Per-edge priority: flush_i > stall_i > normal load.
- flush_i=1: all control outputs and aluop_o cleared to 0, valid_o=0, data/address outputs cleared to 0. Applies even if stall_i=1 concurrently.
- stall_i=1, flush_i=0: every output holds previous value, including valid_o.
- Normal load (both 0): data/address fields load inputs unconditionally. Control fields load inputs; valid_o <= ctrl_sel_i.
- ctrl_sel_i=0 during normal load: control fields forced to 0 regardless of inputs (defensive re-bubble), valid_o=0; data fields still load.
- Invariant: valid_o=0 implies regwrite_o=memwrite_o=memread_o=branch_o=0.
- No combinational path input->output.

Optional Feature:
BUBBLE_CNT_EN: adds output bubble_cnt_o [CNT_W-1:0]; increments by 1 on each rising edge where stall_i=0 and (flush_i=1 or ctrl_sel_i=0); saturates at all-ones (no wrap); reset to 0 by rst_i. Without macro: port and counter absent, behaviour otherwise identical.

Test Plan:
- Reset: drive rst_i=0 with all inputs 1 -> every output 0, valid_o=0 immediately, before any clock edge.
- Normal load: ctrl_sel_i=1, regwrite_i=1, aluop_i=2'b10, rs_data_i=32'h0000_1234, rd_i=5'd9 -> next edge regwrite_o=1, aluop_o=2'b10, rs_data_o=32'h0000_1234, rd_o=9, valid_o=1.
- Bubble: ctrl_sel_i=0, memwrite_i=1, rt_data_i=32'hDEAD_BEEF -> memwrite_o=0, valid_o=0, rt_data_o=32'hDEAD_BEEF.
- Stall: load instruction with pc4_i=32'h40, then stall_i=1 for 3 cycles with pc4_i=32'h44 -> pc4_o stays 32'h40, valid_o stays 1; releases to 32'h44 on edge after stall_i drops.
- Flush+stall same cycle: valid instruction held, assert flush_i=1 and stall_i=1 -> next edge all outputs 0, valid_o=0.
- BUBBLE_CNT_EN with CNT_W=2: 5 bubble cycles -> bubble_cnt_o sequence 1,2,3,3,3; stalled bubble cycles do not increment.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall (hold), flush (kill) and valid-bit bubble tracking.
// Optional macro BUBBLE_CNT_EN adds a saturating bubble counter output (bubble_cnt_o).
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ctrl_sel_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic              branch_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              alusrc_i,
    input  logic              regdst_i,
    input  logic [1:0]        aluop_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic              branch_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic              alusrc_o,
    output logic              regdst_o,
    output logic [1:0]        aluop_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_AW-1:0] rs_o,
    output logic [REG_AW-1:0] rt_o,
    output logic [REG_AW-1:0] rd_o,
`ifdef BUBBLE_CNT_EN
    output logic [CNT_W-1:0]  bubble_cnt_o,
`endif
    output logic              valid_o
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    localparam int CTRL_W = 9;

    logic [CTRL_W-1:0] ctrl_in;
    logic [CTRL_W-1:0] ctrl_q;

    assign ctrl_in = {regwrite_i, memtoreg_i, branch_i, memread_i,
                      memwrite_i, alusrc_i, regdst_i, aluop_i};

    assign {regwrite_o, memtoreg_o, branch_o, memread_o,
            memwrite_o, alusrc_o, regdst_o, aluop_o} = ctrl_q;

    // Control is zeroed whenever the slot is not a real instruction, so
    // valid_o=0 always implies no architectural side effects downstream.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q    <= '0;
            valid_o   <= 1'b0;
            pc4_o     <= '0;
            rs_data_o <= '0;
            rt_data_o <= '0;
            imm_o     <= '0;
            rs_o      <= '0;
            rt_o      <= '0;
            rd_o      <= '0;
        end else if (flush_i) begin
            ctrl_q    <= '0;
            valid_o   <= 1'b0;
            pc4_o     <= '0;
            rs_data_o <= '0;
            rt_data_o <= '0;
            imm_o     <= '0;
            rs_o      <= '0;
            rt_o      <= '0;
            rd_o      <= '0;
        end else if (!stall_i) begin
            ctrl_q    <= ctrl_sel_i ? ctrl_in : '0;
            valid_o   <= ctrl_sel_i;
            pc4_o     <= pc4_i;
            rs_data_o <= rs_data_i;
            rt_data_o <= rt_data_i;
            imm_o     <= imm_i;
            rs_o      <= rs_i;
            rt_o      <= rt_i;
            rd_o      <= rd_i;
        end
    end

`ifdef BUBBLE_CNT_EN
    // Stalled edges never count, even with flush asserted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (!stall_i && (flush_i || !ctrl_sel_i) && !(&bubble_cnt_o)) begin
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg; covers the bubble counter when BUBBLE_CNT_EN is defined.
module tb_id_ex_pipe_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic stall, flush, ctrl_sel;
    logic regwrite, memtoreg, branch, memread, memwrite, alusrc, regdst;
    logic [1:0] aluop;
    logic [DATA_W-1:0] pc4, rs_data, rt_data, imm;
    logic [REG_AW-1:0] rs, rt, rd;

    logic regwrite_q, memtoreg_q, branch_q, memread_q, memwrite_q, alusrc_q, regdst_q;
    logic [1:0] aluop_q;
    logic [DATA_W-1:0] pc4_q, rs_data_q, rt_data_q, imm_q;
    logic [REG_AW-1:0] rs_q, rt_q, rd_q;
    logic valid_q;
`ifdef BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt;
`endif

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .ctrl_sel_i(ctrl_sel),
        .regwrite_i(regwrite), .memtoreg_i(memtoreg), .branch_i(branch), .memread_i(memread),
        .memwrite_i(memwrite), .alusrc_i(alusrc), .regdst_i(regdst), .aluop_i(aluop),
        .pc4_i(pc4), .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_i(imm),
        .rs_i(rs), .rt_i(rt), .rd_i(rd),
        .regwrite_o(regwrite_q), .memtoreg_o(memtoreg_q), .branch_o(branch_q),
        .memread_o(memread_q), .memwrite_o(memwrite_q), .alusrc_o(alusrc_q),
        .regdst_o(regdst_q), .aluop_o(aluop_q),
        .pc4_o(pc4_q), .rs_data_o(rs_data_q), .rt_data_o(rt_data_q), .imm_o(imm_q),
        .rs_o(rs_q), .rt_o(rt_q), .rd_o(rd_q),
`ifdef BUBBLE_CNT_EN
        .bubble_cnt_o(bubble_cnt),
`endif
        .valid_o(valid_q)
    );

    logic [8:0] ctrl_q;
    assign ctrl_q = {regwrite_q, memtoreg_q, branch_q, memread_q,
                     memwrite_q, alusrc_q, regdst_q, aluop_q};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic v);
        stall = 1'b0; flush = 1'b0; ctrl_sel = v;
        {regwrite, memtoreg, branch, memread, memwrite, alusrc, regdst} = {7{v}};
        aluop = {2{v}};
        pc4 = {DATA_W{v}}; rs_data = {DATA_W{v}}; rt_data = {DATA_W{v}}; imm = {DATA_W{v}};
        rs = {REG_AW{v}}; rt = {REG_AW{v}}; rd = {REG_AW{v}};
    endtask

    task automatic test_reset();
        drive_all(1'b1);
        stall = 1'b1; flush = 1'b1;
        rst_n = 1'b0;
        #2;
        asserts++;
        if ({ctrl_q, valid_q} !== 10'b0) begin
            $display("FAIL reset_ctrl got %b exp 0", {ctrl_q, valid_q}); fails++;
        end
        asserts++;
        if ({pc4_q, rs_data_q, rt_data_q, imm_q, rs_q, rt_q, rd_q} !== '0) begin
            $display("FAIL reset_data got %h exp 0",
                     {pc4_q, rs_data_q, rt_data_q, imm_q, rs_q, rt_q, rd_q}); fails++;
        end
        stall = 1'b0; flush = 1'b0;
        step();
        asserts++;
        if (valid_q !== 1'b0 || pc4_q !== '0) begin
            $display("FAIL reset_held valid=%b pc4=%h exp 0/0", valid_q, pc4_q); fails++;
        end
        drive_all(1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_normal_load();
        drive_all(1'b0);
        ctrl_sel = 1'b1; regwrite = 1'b1; aluop = 2'b10;
        rs_data = 32'h0000_1234; rd = 5'd9;
        step();
        asserts++;
        if (regwrite_q !== 1'b1 || aluop_q !== 2'b10 || valid_q !== 1'b1) begin
            $display("FAIL load_ctrl regwrite=%b aluop=%b valid=%b exp 1/10/1",
                     regwrite_q, aluop_q, valid_q); fails++;
        end
        asserts++;
        if (rs_data_q !== 32'h0000_1234 || rd_q !== 5'd9) begin
            $display("FAIL load_data rs_data=%h rd=%0d exp 00001234/9", rs_data_q, rd_q); fails++;
        end
        drive_all(1'b1);
        aluop = 2'b01; pc4 = 32'h1000_0004; imm = 32'hFFFF_FFF0; rs = 5'd3; rt = 5'd17; rd = 5'd30;
        rs_data = 32'hA5A5_0001; rt_data = 32'h0F0F_F0F0;
        step();
        asserts++;
        if (ctrl_q !== 9'b1_1111_1101 || valid_q !== 1'b1) begin
            $display("FAIL load_all_ctrl got %b valid=%b exp 111111101/1", ctrl_q, valid_q); fails++;
        end
        asserts++;
        if ({pc4_q, imm_q, rs_q, rt_q, rd_q, rs_data_q, rt_data_q} !==
            {32'h1000_0004, 32'hFFFF_FFF0, 5'd3, 5'd17, 5'd30, 32'hA5A5_0001, 32'h0F0F_F0F0}) begin
            $display("FAIL load_all_data pc4=%h imm=%h rs=%0d rt=%0d rd=%0d", pc4_q, imm_q, rs_q, rt_q, rd_q);
            fails++;
        end
    endtask

    task automatic test_bubble();
        drive_all(1'b1);
        ctrl_sel = 1'b0; rt_data = 32'hDEAD_BEEF; rd = 5'd4;
        step();
        asserts++;
        if (memwrite_q !== 1'b0 || valid_q !== 1'b0 || ctrl_q !== 9'b0) begin
            $display("FAIL bubble_ctrl memwrite=%b valid=%b ctrl=%b exp 0/0/0", memwrite_q, valid_q, ctrl_q);
            fails++;
        end
        asserts++;
        if (rt_data_q !== 32'hDEAD_BEEF || rd_q !== 5'd4) begin
            $display("FAIL bubble_data rt_data=%h rd=%0d exp deadbeef/4", rt_data_q, rd_q); fails++;
        end
    endtask

    task automatic test_stall();
        drive_all(1'b0);
        ctrl_sel = 1'b1; memread = 1'b1; pc4 = 32'h40;
        step();
        asserts++;
        if (pc4_q !== 32'h40 || valid_q !== 1'b1) begin
            $display("FAIL stall_setup pc4=%h valid=%b exp 40/1", pc4_q, valid_q); fails++;
        end
        stall = 1'b1; pc4 = 32'h44; memread = 1'b0; ctrl_sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            asserts++;
            if (pc4_q !== 32'h40 || valid_q !== 1'b1 || memread_q !== 1'b1) begin
                $display("FAIL stall_hold_%0d pc4=%h valid=%b memread=%b exp 40/1/1",
                         i, pc4_q, valid_q, memread_q); fails++;
            end
        end
        stall = 1'b0; ctrl_sel = 1'b1;
        step();
        asserts++;
        if (pc4_q !== 32'h44 || memread_q !== 1'b0 || valid_q !== 1'b1) begin
            $display("FAIL stall_release pc4=%h memread=%b valid=%b exp 44/0/1", pc4_q, memread_q, valid_q);
            fails++;
        end
    endtask

    task automatic test_flush();
        drive_all(1'b1);
        step();
        asserts++;
        if (valid_q !== 1'b1 || ctrl_q !== 9'h1FF) begin
            $display("FAIL flush_setup valid=%b ctrl=%b exp 1/111111111", valid_q, ctrl_q); fails++;
        end
        flush = 1'b1; stall = 1'b1;
        step();
        asserts++;
        if ({ctrl_q, valid_q} !== 10'b0 ||
            {pc4_q, rs_data_q, rt_data_q, imm_q, rs_q, rt_q, rd_q} !== '0) begin
            $display("FAIL flush_stall ctrl=%b valid=%b pc4=%h exp all 0", ctrl_q, valid_q, pc4_q); fails++;
        end
        drive_all(1'b1);
        step();
        flush = 1'b1;
        step();
        asserts++;
        if ({ctrl_q, valid_q} !== 10'b0 || pc4_q !== '0 || rd_q !== '0) begin
            $display("FAIL flush_plain ctrl=%b valid=%b pc4=%h exp all 0", ctrl_q, valid_q, pc4_q); fails++;
        end
    endtask

    task automatic test_reset_mid_stall();
        drive_all(1'b1);
        step();
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        asserts++;
        if (valid_q !== 1'b0 || ctrl_q !== 9'b0 || imm_q !== '0) begin
            $display("FAIL reset_mid_stall valid=%b ctrl=%b imm=%h exp 0/0/0", valid_q, ctrl_q, imm_q); fails++;
        end
        step();
        rst_n = 1'b1;
        drive_all(1'b0);
    endtask

`ifdef BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        logic [CNT_W-1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst_n = 1'b0;
        #1;
        asserts++;
        if (bubble_cnt !== '0) begin
            $display("FAIL cnt_reset got %0d exp 0", bubble_cnt); fails++;
        end
        rst_n = 1'b1;
        drive_all(1'b0);
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            step();
            asserts++;
            if (bubble_cnt !== exp_seq[i]) begin
                $display("FAIL cnt_seq_%0d got %0d exp %0d", i, bubble_cnt, exp_seq[i]); fails++;
            end
        end
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive_all(1'b0);
        stall = 1'b1; flush = 1'b1;
        step();
        step();
        asserts++;
        if (bubble_cnt !== '0) begin
            $display("FAIL cnt_stalled got %0d exp 0", bubble_cnt); fails++;
        end
        stall = 1'b0; flush = 1'b0; ctrl_sel = 1'b1;
        step();
        asserts++;
        if (bubble_cnt !== '0) begin
            $display("FAIL cnt_real_instr got %0d exp 0", bubble_cnt); fails++;
        end
        flush = 1'b1;
        step();
        asserts++;
        if (bubble_cnt !== 2'd1) begin
            $display("FAIL cnt_flush got %0d exp 1", bubble_cnt); fails++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal_load();
        test_bubble();
        test_stall();
        test_flush();
        test_reset_mid_stall();
`ifdef BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
